mem_arbiter_r32i: RTL and testbench

Parametrised memory access unit that replaces the single shared-RAM address mux in the processor top.
- Arbitrates NPorts requesters (instruction fetch, load/store, future DMA) onto one word-wide RAM port using round-robin.
- Adds byte/halfword/word (and doubleword when dataW=64) loads and stores, with byte enables and sign/zero extension.
- Reports misaligned accesses as errors.
- Supports RAM read latency from 0 (zero-delay RAM) upward.

---
 rtl/mem_arbiter_r32i.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter_r32i.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_r32i.sv
// rtl/mem_arbiter_r32i.sv - round-robin multi-port byte/half/word/dword memory access unit
module mem_arbiter_r32i #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16,
    parameter int NPorts      = 2,
    parameter int RAMLatency  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPorts-1:0]       ReqValid,
    output logic [NPorts-1:0]       ReqReady,
    input  logic [NPorts-1:0]       ReqWrite,
    input  logic [2*NPorts-1:0]     ReqSize,
    input  logic [NPorts-1:0]       ReqSigned,
    input  logic [NPorts*dataW-1:0] ReqAddr,
    input  logic [NPorts*dataW-1:0] ReqData,
    output logic [NPorts-1:0]       RespValid,
    output logic                    RespErr,
    output logic [dataW-1:0]        RespData,
    output logic [RAMAddrSize-1:0]  MemAddr,
    output logic [dataW-1:0]        MemWData,
    output logic [dataW/8-1:0]      MemByteEn,
    output logic                    MemWrite,
    output logic                    MemRead,
    input  logic [dataW-1:0]        MemRData
);
    localparam int B     = dataW / 8;
    localparam int Log2B = $clog2(B);
    localparam int AddrW = RAMAddrSize + Log2B;
    localparam int IdxW  = $clog2(dataW);
    localparam int PtrW  = (NPorts > 1) ? $clog2(NPorts) : 1;
    localparam int CntW  = (RAMLatency > 1) ? $clog2(RAMLatency) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, stateNext;

    logic [PtrW-1:0]  rrPtr, ownerQ, grantIdx;
    logic             grantFound, handshake;
    logic             writeQ, signedQ, errQ;
    logic [1:0]       sizeQ;
    logic [AddrW-1:0] addrQ;
    logic [dataW-1:0] dataQ, respDataQ, loadExt;
    logic [CntW-1:0]  cntQ;
    logic [Log2B-1:0] off, alignMask;
    logic             accErr, capture;
    logic             unusedAddr;

    // Address bits above the RAM range are deliberately dropped (word-address wrap).
    assign unusedAddr = ^ReqAddr;

    always_comb begin
        int idx;
        idx        = 0;
        grantIdx   = '0;
        grantFound = 1'b0;
        for (int i = 0; i < NPorts; i++) begin
            idx = (int'(rrPtr) + i) % NPorts;
            if (!grantFound && ReqValid[idx]) begin
                grantFound = 1'b1;
                grantIdx   = PtrW'(idx);
            end
        end
    end

    assign handshake = reset && (state == IDLE) && grantFound;

    always_comb begin
        ReqReady = '0;
        if (handshake) ReqReady[grantIdx] = 1'b1;
    end

    assign off       = addrQ[Log2B-1:0];
    assign alignMask = Log2B'((32'd1 << sizeQ) - 32'd1);
    assign accErr    = (int'(sizeQ) > Log2B) || ((off & alignMask) != '0);
    assign capture   = !writeQ && !accErr &&
                       (((state == ISSUE) && (RAMLatency == 0)) || ((state == WAIT) && (cntQ == '0)));

    // Right-justify the addressed lanes, then extend from the access size's top bit.
    always_comb begin
        logic [dataW-1:0] shifted;
        int               nBits;
        logic             signBit;
        shifted = MemRData >> {off, 3'b000};
        nBits   = 8 << sizeQ;
        if (nBits > dataW) nBits = dataW;
        signBit = signedQ & shifted[IdxW'(nBits - 1)];
        loadExt = '0;
        for (int i = 0; i < dataW; i++) begin
            loadExt[i] = (i < nBits) ? shifted[i] : signBit;
        end
    end

    always_comb begin
        MemAddr   = '0;
        MemWData  = '0;
        MemByteEn = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        if (state == ISSUE || state == WAIT) MemAddr = addrQ[AddrW-1:Log2B];
        if (state == ISSUE && !accErr) begin
            if (writeQ) begin
                MemWrite = 1'b1;
                MemWData = dataQ << {off, 3'b000};
                for (int i = 0; i < B; i++) begin
                    MemByteEn[i] = (i >= int'(off)) && (i < int'(off) + (1 << sizeQ));
                end
            end else begin
                MemRead = 1'b1;
            end
        end
        if (state == WAIT) MemRead = 1'b1;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (handshake) stateNext = ISSUE;
            ISSUE:   stateNext = (accErr || writeQ || RAMLatency == 0) ? RESP : WAIT;
            WAIT:    if (cntQ == '0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        RespValid = '0;
        if (state == RESP) RespValid[ownerQ] = 1'b1;
    end
    assign RespErr  = (state == RESP) && errQ;
    assign RespData = (state == RESP) ? respDataQ : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rrPtr     <= '0;
            ownerQ    <= '0;
            writeQ    <= 1'b0;
            signedQ   <= 1'b0;
            sizeQ     <= '0;
            addrQ     <= '0;
            dataQ     <= '0;
            errQ      <= 1'b0;
            cntQ      <= '0;
            respDataQ <= '0;
        end else begin
            state <= stateNext;
            if (handshake) begin
                ownerQ    <= grantIdx;
                rrPtr     <= (grantIdx == PtrW'(NPorts - 1)) ? '0 : grantIdx + 1'b1;
                writeQ    <= ReqWrite[grantIdx];
                signedQ   <= ReqSigned[grantIdx];
                sizeQ     <= ReqSize[int'(grantIdx)*2 +: 2];
                addrQ     <= ReqAddr[int'(grantIdx)*dataW +: AddrW];
                dataQ     <= ReqData[int'(grantIdx)*dataW +: dataW];
                errQ      <= 1'b0;
                respDataQ <= '0;
            end
            if (state == ISSUE) begin
                errQ <= accErr;
                cntQ <= CntW'((RAMLatency > 0) ? RAMLatency - 1 : 0);
            end
            if (state == WAIT && cntQ != '0) cntQ <= cntQ - 1'b1;
            if (capture) respDataQ <= loadExt;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_r32i.sv
// tb/tb_mem_arbiter_r32i.sv - randomized self-checking bench with byte-level memory reference model
module tb_mem_arbiter_r32i;
    localparam int NP = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [1:0]  reqValid, reqReady, reqWrite, reqSigned, respValid;
    logic [3:0]  reqSize;
    logic [63:0] reqAddr, reqData;
    logic        respErr, memWrite, memRead;
    logic [31:0] respData, memWData, memRData;
    logic [15:0] memAddr;
    logic [3:0]  memByteEn;

    mem_arbiter_r32i #(.dataW(32), .RAMAddrSize(16), .NPorts(2), .RAMLatency(1)) dut (
        .clock(clock), .reset(reset),
        .ReqValid(reqValid), .ReqReady(reqReady), .ReqWrite(reqWrite), .ReqSize(reqSize),
        .ReqSigned(reqSigned), .ReqAddr(reqAddr), .ReqData(reqData),
        .RespValid(respValid), .RespErr(respErr), .RespData(respData),
        .MemAddr(memAddr), .MemWData(memWData), .MemByteEn(memByteEn),
        .MemWrite(memWrite), .MemRead(memRead), .MemRData(memRData)
    );

    logic [0:0]  zValid, zReady, zWrite, zSigned, zRespValid;
    logic [1:0]  zSize;
    logic [31:0] zAddr, zData, zRespData, zWData, zRData;
    logic        zErr, zMemWrite, zMemRead;
    logic [15:0] zMemAddr;
    logic [3:0]  zBe;

    mem_arbiter_r32i #(.dataW(32), .RAMAddrSize(16), .NPorts(1), .RAMLatency(0)) dutZero (
        .clock(clock), .reset(reset),
        .ReqValid(zValid), .ReqReady(zReady), .ReqWrite(zWrite), .ReqSize(zSize),
        .ReqSigned(zSigned), .ReqAddr(zAddr), .ReqData(zData),
        .RespValid(zRespValid), .RespErr(zErr), .RespData(zRespData),
        .MemAddr(zMemAddr), .MemWData(zWData), .MemByteEn(zBe),
        .MemWrite(zMemWrite), .MemRead(zMemRead), .MemRData(zRData)
    );
    assign zRData = (zMemAddr == 16'h0) ? 32'hDEADBEEF : 32'h0;

    logic [31:0] ram [0:65535];
    logic [7:0]  refMem [0:262143];
    int nTests = 0;
    int nFail  = 0;
    int rrPtr  = 0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (memWrite) ram[memAddr] <= mergeBytes(ram[memAddr], memWData, memByteEn);
        if (memRead)  memRData <= ram[memAddr];
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit refErr(input int unsigned addr, input int size);
        return (size > 2) || ((addr % (1 << size)) != 0);
    endfunction

    function automatic logic [31:0] refLoad(input int unsigned addr, input int size, input bit sgn);
        logic [63:0] v;
        int n;
        n = 1 << size;
        v = 64'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = refMem[(addr + k) & 32'h3FFFF];
        if (sgn && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v[31:0];
    endfunction

    task automatic refStore(input int unsigned addr, input int size, input logic [31:0] data);
        for (int k = 0; k < (1 << size); k++) refMem[(addr + k) & 32'h3FFFF] = data[8*k +: 8];
    endtask

    task automatic doTxn(input int p, input bit w, input int size, input bit sgn,
                         input int unsigned addr, input logic [31:0] data, output logic [31:0] got);
        bit err;
        logic [31:0] expData, expWd;
        logic [3:0]  expBe;
        int lat, off;
        err = refErr(addr, size);
        off = addr & 3;
        expData = (w || err) ? 32'h0 : refLoad(addr, size, sgn);
        expBe   = (w && !err) ? 4'(((1 << (1 << size)) - 1) << off) : 4'h0;
        expWd   = (w && !err) ? (data << (8*off)) : 32'h0;
        @(negedge clock);
        reqValid = 2'b00;
        reqValid[p] = 1'b1;
        reqWrite[p] = w;
        reqSize[2*p +: 2] = 2'(size);
        reqSigned[p] = sgn;
        reqAddr[32*p +: 32] = addr;
        reqData[32*p +: 32] = data;
        #1;
        for (int c = 0; c < 20 && reqReady == 2'b00; c++) begin
            @(negedge clock);
            #1;
        end
        checkVal("grant", reqReady, 2'b01 << p);
        @(posedge clock);
        rrPtr = (p + 1) % NP;
        #1;
        reqValid[p] = 1'b0;
        checkVal("issueWrite", memWrite, w && !err);
        checkVal("issueRead", memRead, !w && !err);
        checkVal("byteEn", memByteEn, expBe);
        checkVal("wData", memWData, expWd);
        if (!err) checkVal("memAddr", memAddr, (addr >> 2) & 32'hFFFF);
        if (w && !err) refStore(addr, size, data);
        lat = 1;
        while (respValid == 2'b00 && lat < 12) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkVal("latency", lat, (w || err) ? 2 : 3);
        checkVal("respOwner", respValid, 2'b01 << p);
        checkVal("respErr", respErr, err);
        checkVal("respData", respData, expData);
        got = respData;
    endtask

    initial begin
        logic [31:0] got, w32;
        int cnt0, cnt1, g, p;
        bit quiet;
        reset = 1'b0;
        reqValid = '0; reqWrite = '0; reqSize = '0; reqSigned = '0; reqAddr = '0; reqData = '0;
        zValid = '0; zWrite = '0; zSize = '0; zSigned = '0; zAddr = '0; zData = '0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 32'h0;
            for (int k = 0; k < 4; k++) refMem[4*i + k] = 8'h0;
        end
        for (int i = 0; i < 16; i++) begin
            w32 = $urandom();
            ram[i] = w32;
            for (int k = 0; k < 4; k++) refMem[4*i + k] = w32[8*k +: 8];
        end
        w32 = 32'h80FF1234;
        ram[16'h40] = w32;
        for (int k = 0; k < 4; k++) refMem[32'h100 + k] = w32[8*k +: 8];

        #12;
        checkVal("rstReady", reqReady, 0);
        checkVal("rstResp", {respValid, respErr, respData}, 0);
        checkVal("rstMem", {memAddr, memWData, memByteEn, memWrite, memRead}, 0);
        checkVal("rstZero", {zReady, zRespValid, zMemRead, zMemWrite}, 0);
        @(negedge clock);
        reset = 1'b1;

        doTxn(0, 0, 1, 1, 32'h102, 0, got);
        checkVal("halfSigned", got, 32'hFFFF80FF);
        doTxn(1, 0, 1, 0, 32'h102, 0, got);
        checkVal("halfUnsigned", got, 32'h000080FF);
        doTxn(1, 1, 0, 0, 32'h103, 32'h000000AB, got);
        doTxn(0, 0, 2, 0, 32'h100, 0, got);
        checkVal("byteStoreRead", got, 32'hABFF1234);
        doTxn(0, 0, 2, 0, 32'h102, 0, got);
        doTxn(1, 0, 3, 0, 32'h100, 0, got);
        doTxn(0, 1, 2, 0, 32'h0004_0010, 32'hCAFEF00D, got);
        doTxn(1, 0, 2, 0, 32'h10, 0, got);
        checkVal("wrapRead", got, 32'hCAFEF00D);

        for (int t = 0; t < 60; t++) begin
            doTxn($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), ($urandom() & 32'hFFFC_0000) | $urandom_range(0, 63),
                  $urandom(), got);
        end

        @(negedge clock);
        reqWrite = 2'b00; reqSize = 4'b1010; reqSigned = 2'b00;
        reqAddr = {32'h4, 32'h0};
        reqValid = 2'b11;
        cnt0 = 0; cnt1 = 0;
        for (int t = 0; t < 4; t++) begin
            #1;
            for (int c = 0; c < 20 && reqReady == 2'b00; c++) begin
                @(negedge clock);
                #1;
            end
            g = rrPtr;
            checkVal("rrGrant", reqReady, 2'b01 << g);
            if (reqReady == 2'b01) cnt0++;
            if (reqReady == 2'b10) cnt1++;
            rrPtr = (g + 1) % NP;
            @(posedge clock);
            #1;
            for (int c = 0; c < 12 && respValid == 2'b00; c++) begin
                @(posedge clock);
                #1;
            end
            checkVal("rrResp", respValid, 2'b01 << g);
            checkVal("rrData", respData, refLoad(4*g, 2, 0));
            @(negedge clock);
        end
        reqValid = 2'b00;
        checkVal("rrFair0", cnt0, 2);
        checkVal("rrFair1", cnt1, 2);

        @(negedge clock);
        zValid = 1'b1; zWrite = 1'b0; zSize = 2'd2; zAddr = 32'h0;
        #1;
        checkVal("zReady", zReady, 1);
        @(posedge clock);
        #1;
        zValid = 1'b0;
        checkVal("zIssueRead", zMemRead, 1);
        @(posedge clock);
        #1;
        checkVal("zRespValid", zRespValid, 1);
        checkVal("zRespData", zRespData, 32'hDEADBEEF);
        checkVal("zRespErr", zErr, 0);

        @(negedge clock);
        p = 0;
        reqValid = 2'b01; reqWrite = 2'b00; reqSize = 4'b1010; reqAddr = 64'h0;
        #1;
        for (int c = 0; c < 20 && reqReady == 2'b00; c++) begin
            @(negedge clock);
            #1;
        end
        checkVal("abortGrant", reqReady, 2'b01);
        @(posedge clock);
        #1;
        reqValid = 2'b00;
        @(posedge clock);
        #1;
        checkVal("waitRead", memRead, 1);
        reset = 1'b0;
        #1;
        checkVal("rstRead", memRead, 0);
        checkVal("rstRespValid", respValid, 0);
        rrPtr = 0;
        @(negedge clock);
        reset = 1'b1;
        reqValid = 2'b11;
        #1;
        checkVal("postRstGrant", reqReady, 2'b01 << rrPtr);
        reqValid = 2'b00;
        quiet = 1'b1;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (respValid != 2'b00 || memRead || memWrite) quiet = 1'b0;
        end
        checkVal("droppedTxn", quiet, 1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
